// File: rtl/imem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and the load/store unit; owner-tagged read return.
// Latency: grant is combinational, read data returns the cycle after the grant; one access per cycle.
// Backpressure: a losing requester holds its request until granted; data wins unless fetch is starved.
// Optional FEWCORE_ARB_PERF_EN adds saturating per-requester stall counters.
module imem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int PCLEN      = 10,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [PCLEN-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [XLEN-1:0]  if_rdata,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [PCLEN-1:0] dm_addr,
    input  logic [XLEN-1:0]  dm_wdata,
    output logic             dm_gnt,
    output logic             dm_rvalid,
    output logic [XLEN-1:0]  dm_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [PCLEN-1:0] mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata
`ifdef FEWCORE_ARB_PERF_EN
    ,
    output logic [15:0]      perf_if_stall,
    output logic [15:0]      perf_dm_stall
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t     owner;
    logic [3:0] starve_cnt;
    logic       force_if;
    logic       if_win;
    logic       dm_win;

    assign force_if = (starve_cnt == STARVE_LIM);

    // Forcing fetch only matters while fetch is actually asking.
    always_comb begin
        dm_win = reset & dm_req & ~(force_if & if_req);
        if_win = reset & if_req & ~dm_win;
    end

    always_comb begin
        if_gnt    = if_win;
        dm_gnt    = dm_win;
        mem_en    = if_win | dm_win;
        mem_we    = dm_win & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_win) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_win) begin
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= OWN_NONE;
        end else if (if_win) begin
            owner <= OWN_IF;
        end else if (dm_win && !dm_we) begin
            owner <= OWN_DM;
        end else begin
            owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (if_win || !if_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign if_rvalid = (owner == OWN_IF);
    assign dm_rvalid = (owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

`ifdef FEWCORE_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_stall <= '0;
            perf_dm_stall <= '0;
        end else begin
            if (if_req && !if_win && perf_if_stall != 16'hFFFF) begin
                perf_if_stall <= perf_if_stall + 16'd1;
            end
            if (dm_req && !dm_win && perf_dm_stall != 16'hFFFF) begin
                perf_dm_stall <= perf_dm_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a write-first synchronous memory attached to mem_*.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef FEWCORE_ARB_PERF_EN
    logic [15:0] perf_if_stall;
    logic [15:0] perf_dm_stall;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    imem_port_arbiter #(.XLEN(32), .PCLEN(10), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef FEWCORE_ARB_PERF_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall)
`endif
    );

    // Write-first single-port memory, word-indexed.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                mem_rdata          <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller then drives inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] init_word(input int idx);
        return 32'hA500_0000 | 32'(idx);
    endfunction

    logic [4:0] exp_dg;
    logic [4:0] exp_ig;
    logic [4:0] exp_drv;
    logic [4:0] exp_irv;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem_rdata = '0;
        reset = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Requests under reset see nothing.
        for (int i = 0; i < 3; i++) begin
            cyc();
            if_req = ~if_req; dm_req = (i != 1); if_addr = 10'h004; dm_addr = 10'h008;
            settle();
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
            chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        end

        // Release: fetch wins immediately, then a fetch stream 0,4,8.
        cyc();
        reset = 1'b1; if_req = 1'b1; if_addr = 10'h000; dm_req = 1'b0;
        settle();
        chk("rel_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("rel_mem_addr", {22'd0, mem_addr}, 32'h0);
        chk("rel_mem_en", {31'd0, mem_en}, 32'd1);
`ifdef FEWCORE_ARB_PERF_EN
        chk("rel_perf_if", {16'd0, perf_if_stall}, 32'd0);
`endif
        for (int i = 1; i < 3; i++) begin
            cyc();
            if_addr = 10'(4 * i);
            settle();
            chk("fs_if_gnt", {31'd0, if_gnt}, 32'd1);
            chk("fs_mem_addr", {22'd0, mem_addr}, 32'(4 * i));
            chk("fs_mem_we", {31'd0, mem_we}, 32'd0);
            chk("fs_if_rvalid", {31'd0, if_rvalid}, 32'd1);
            chk("fs_if_rdata", if_rdata, init_word(i - 1));
            chk("fs_dm_rdata", dm_rdata, 32'd0);
        end
        cyc();
        if_req = 1'b0;
        settle();
        chk("fs_idle_en", {31'd0, mem_en}, 32'd0);
        chk("fs_idle_addr", {22'd0, mem_addr}, 32'd0);
        chk("fs_last_rdata", if_rdata, init_word(2));
        cyc();
        settle();
        chk("fs_end_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("fs_end_rdata", if_rdata, 32'd0);

        // Contention: data wins 3 cycles, fetch forced on the 4th.
        exp_dg = 5'b10111; exp_ig = 5'b01000; exp_drv = 5'b01110; exp_irv = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 10'h00C; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h040;
            settle();
            chk("ct_dm_gnt", {31'd0, dm_gnt}, {31'd0, exp_dg[i]});
            chk("ct_if_gnt", {31'd0, if_gnt}, {31'd0, exp_ig[i]});
            chk("ct_mem_addr", {22'd0, mem_addr}, exp_ig[i] ? 32'h00C : 32'h040);
            chk("ct_dm_rvalid", {31'd0, dm_rvalid}, {31'd0, exp_drv[i]});
            chk("ct_if_rvalid", {31'd0, if_rvalid}, {31'd0, exp_irv[i]});
            chk("ct_dm_rdata", dm_rdata, exp_drv[i] ? init_word(16) : 32'd0);
            chk("ct_if_rdata", if_rdata, exp_irv[i] ? init_word(3) : 32'd0);
`ifdef FEWCORE_ARB_PERF_EN
            if (i == 4) begin
                chk("perf_if_stall", {16'd0, perf_if_stall}, 32'd3);
                chk("perf_dm_stall", {16'd0, perf_dm_stall}, 32'd1);
            end
`endif
        end
        cyc();
        if_req = 1'b0; dm_req = 1'b0;
        settle();
        chk("ct_tail_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("ct_tail_if", {31'd0, if_rvalid}, 32'd0);

        // Write 0x10 then read it back.
        cyc();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h010; dm_wdata = 32'hDEADBEEF;
        settle();
        chk("wr_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        cyc();
        dm_we = 1'b0; dm_wdata = '0;
        settle();
        chk("wr_no_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        cyc();
        dm_req = 1'b0;
        settle();
        chk("raw_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("raw_rdata", dm_rdata, 32'hDEADBEEF);

        // Starve counter saturated, then fetch withdraws: data still wins and the counter clears.
        for (int i = 0; i < 3; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 10'h020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h044;
            settle();
            chk("sv_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        end
        cyc();
        if_req = 1'b0;
        settle();
        chk("force_noop_dm", {31'd0, dm_gnt}, 32'd1);
        chk("force_noop_if", {31'd0, if_gnt}, 32'd0);
        cyc();
        if_req = 1'b1;
        settle();
        chk("cnt_clear_dm", {31'd0, dm_gnt}, 32'd1);
        chk("cnt_clear_if", {31'd0, if_gnt}, 32'd0);
        cyc();
        if_req = 1'b0; dm_req = 1'b0;
        settle();

        // Reset between a fetch grant and its response drops the response.
        cyc();
        if_req = 1'b1; if_addr = 10'h014;
        settle();
        chk("mo_if_gnt", {31'd0, if_gnt}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mo_gnt_rst", {31'd0, if_gnt}, 32'd0);
        chk("mo_en_rst", {31'd0, mem_en}, 32'd0);
        cyc();
        settle();
        chk("mo_no_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("mo_no_rdata", if_rdata, 32'd0);
        cyc();
        reset = 1'b1; if_req = 1'b0;
        settle();
        chk("mo_rel_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
`ifdef FEWCORE_ARB_PERF_EN
        chk("mo_perf_clr", {perf_if_stall, perf_dm_stall}, 32'd0);
`endif
        cyc();
        settle();
        chk("mo_owner_none", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
